// File: rtl/bgr_sar_monitor.sv
// Successive-approximation controller for the bandgap monitor: drives an external R-2R DAC,
// reads a synchronised comparator bit, and averages 2**AVG_LOG2 conversions per result.
module bgr_sar_monitor #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int AVG_LOG2      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic             cont,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    output logic             busy
);
    localparam int IDX_W     = $clog2(WIDTH);
    localparam int CNT_W     = $clog2(SETTLE_CYCLES + 1);
    localparam int CONV_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int ACC_W     = WIDTH + AVG_LOG2;
    localparam int LAST_CONV = (1 << AVG_LOG2) - 1;

    localparam logic [WIDTH-1:0] MIDSCALE    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0] MSB_IDX     = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]   settle_q, settle_d;
    logic [CONV_W-1:0]  conv_q, conv_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   dac_q, dac_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic [WIDTH-1:0]   code;

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        settle_d  = settle_q;
        conv_d    = conv_q;
        acc_d     = acc_q;
        dac_d     = dac_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        sync1_d   = cmp_in;
        sync2_d   = sync1_q;
        code      = dac_q;

        case (state_q)
            IDLE: begin
                dac_d = '0;
                if (ena && (start || cont)) begin
                    state_d   = SETTLE;
                    bit_idx_d = MSB_IDX;
                    dac_d     = MIDSCALE;
                    settle_d  = SETTLE_LOAD;
                    conv_d    = '0;
                end
            end
            SETTLE: begin
                settle_d = settle_q - 1'b1;
                if (settle_q == CNT_W'(1)) state_d = SAMPLE;
            end
            SAMPLE: begin
                // Only the second synchroniser flop ever decides a bit.
                code[bit_idx_q] = sync2_q;
                if (bit_idx_q != '0) begin
                    code[bit_idx_q - 1'b1] = 1'b1;
                    bit_idx_d = bit_idx_q - 1'b1;
                    settle_d  = SETTLE_LOAD;
                    dac_d     = code;
                    state_d   = SETTLE;
                end else begin
                    acc_d = acc_q + ACC_W'(code);
                    if (int'(conv_q) < LAST_CONV) begin
                        conv_d    = conv_q + 1'b1;
                        dac_d     = MIDSCALE;
                        bit_idx_d = MSB_IDX;
                        settle_d  = SETTLE_LOAD;
                        state_d   = SETTLE;
                    end else begin
                        dac_d   = code;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                result_d = WIDTH'(acc_q >> AVG_LOG2);
                valid_d  = 1'b1;
                acc_d    = '0;
                conv_d   = '0;
                if (ena && cont) begin
                    dac_d     = MIDSCALE;
                    bit_idx_d = MSB_IDX;
                    settle_d  = SETTLE_LOAD;
                    state_d   = SETTLE;
                end else begin
                    dac_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Dropping ena abandons the measurement without publishing anything.
        if (!ena && state_q != IDLE) begin
            state_d  = IDLE;
            dac_d    = '0;
            acc_d    = '0;
            conv_d   = '0;
            valid_d  = 1'b0;
            result_d = result_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            settle_q  <= '0;
            conv_q    <= '0;
            acc_q     <= '0;
            dac_q     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            settle_q  <= settle_d;
            conv_q    <= conv_d;
            acc_q     <= acc_d;
            dac_q     <= dac_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
        end
    end

    assign dac_code = dac_q;
    assign result   = result_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_bgr_sar_monitor.sv
// Directed bench for bgr_sar_monitor with an ideal comparator model cmp_in = (dac_code <= T).
module tb_bgr_sar_monitor;
    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       start;
    logic       cont;
    logic       cmp_in;
    logic [7:0] dac_code;
    logic [7:0] result;
    logic       valid;
    logic       busy;
    logic [7:0] t_val;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] t;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[7];

    bgr_sar_monitor #(.WIDTH(8), .SETTLE_CYCLES(4), .AVG_LOG2(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .start    (start),
        .cont     (cont),
        .cmp_in   (cmp_in),
        .dac_code (dac_code),
        .result   (result),
        .valid    (valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    assign cmp_in = (dac_code <= t_val);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!valid && n < budget);
        if (!valid) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: no valid within %0d cycles", budget);
        end
    endtask

    task automatic run_meas(input logic [7:0] t, input logic [7:0] exp, input string tag);
        int n;
        t_val = t;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_first_dac"}, dac_code, 8'h80);
        check({tag, "_busy_rise"}, busy, 1'b1);
        wait_valid(400, n);
        check({tag, "_latency"}, n, 161);
        check({tag, "_result"}, result, exp);
        check({tag, "_busy_fall"}, busy, 1'b0);
        @(posedge clk);
        #1;
        check({tag, "_valid_pulse"}, valid, 1'b0);
    endtask

    initial begin
        int n;
        int vcount;
        logic [7:0] prev;

        vecs[0] = '{8'hA5, 8'hA5};
        vecs[1] = '{8'h00, 8'h00};
        vecs[2] = '{8'hFF, 8'hFF};
        vecs[3] = '{8'h3C, 8'h3C};
        vecs[4] = '{8'h01, 8'h01};
        vecs[5] = '{8'h80, 8'h80};
        vecs[6] = '{8'h7F, 8'h7F};

        rst = 1'b1; ena = 1'b1; start = 1'b0; cont = 1'b0; t_val = 8'h00;
        #12;
        check("reset_dac", dac_code, 8'h00);
        check("reset_result", result, 8'h00);
        check("reset_valid", valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) run_meas(vecs[i].t, vecs[i].exp, $sformatf("vec%0d", i));

        // Alternating thresholds per conversion: (0x40+0x43)*2 = 0x106, /4 = 0x41.
        t_val = 8'h40;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            t_val = (k % 2 == 1) ? 8'h43 : 8'h40;
            repeat (40) @(posedge clk);
            #1;
        end
        check("avg_pre_valid", valid, 1'b0);
        @(posedge clk);
        #1;
        check("avg_valid", valid, 1'b1);
        check("avg_result", result, 8'h41);

        // Abort with ena low, then ena low + start in IDLE must not start.
        prev = result;
        t_val = 8'h99;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        ena = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_dac", dac_code, 8'h00);
        start = 1'b1;
        vcount = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (valid || busy) vcount++;
        end
        start = 1'b0;
        check("abort_no_activity", vcount, 0);
        check("abort_result_held", result, prev);
        ena = 1'b1;
        run_meas(8'h3C, 8'h3C, "restart");

        // Continuous mode with ignored start pulses mid-run.
        t_val = 8'h77;
        cont = 1'b1;
        wait_valid(400, n);
        check("cont_first_latency", n, 162);
        check("cont_first_result", result, 8'h77);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
                if (n == 80) start = 1'b1;
                if (n == 81) start = 1'b0;
                if (k == 2 && n == 50) cont = 1'b0;
            end while (!valid && n < 400);
            check($sformatf("cont_spacing%0d", k), n, 161);
            check($sformatf("cont_result%0d", k), result, 8'h77);
        end
        check("cont_stop_busy", busy, 1'b0);
        vcount = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (valid || busy) vcount++;
        end
        check("cont_stop_idle", vcount, 0);

        // Asynchronous reset in the middle of SETTLE.
        t_val = 8'h5A;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pre_rst_dac", dac_code, 8'h80);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_dac", dac_code, 8'h00);
        check("rst_async_busy", busy, 1'b0);
        check("rst_async_result", result, 8'h00);
        check("rst_async_valid", valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_idle_busy", busy, 1'b0);
        check("rst_idle_dac", dac_code, 8'h00);
        run_meas(8'h5A, 8'h5A, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
